// File: rtl/ipif_tbl_arbiter_pkg.sv
// Shared definitions for the table-RAM arbiter: host-side FSM states and
// the address-width helper used to size the table ports.
package ipif_tbl_arbiter_pkg;

  // Host access sequencing. H_GAP swallows one cycle after an ack so a
  // level request that drops late is not serviced twice.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H_WRACK,
    ST_H_RD,
    ST_H_RDACK,
    ST_H_GAP
  } arb_state_e;

  // max(1, ceil(log2(n))): a one-row table still needs a 1-bit address.
  function automatic int unsigned tbl_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/ipif_tbl_arbiter.sv
// Arbiter sharing one single-port synchronous table RAM between the host
// register path (tbl_* handshake) and a datapath lookup requester.
// Lookups win by default and may issue every cycle; a starvation counter
// forces the host in after MAX_STARVE consecutive lookup wins.
// Ports:
//   Bus2IP_Clk / Bus2IP_Resetn : clock, asynchronous active-low reset
//   tbl_rd_*  : host read request/ack, registered read data
//   tbl_wr_*  : host write request/ack and data
//   lu_*      : lookup request, combinational grant, data valid 1 cycle later
//   mem_*     : external RAM port (1-cycle read latency)
//   stat_host_stall : saturating count of host-denied cycles
module ipif_tbl_arbiter
  import ipif_tbl_arbiter_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned TBL_NUM_COLS       = 4,
  parameter int unsigned TBL_NUM_ROWS       = 4,
  parameter int unsigned MAX_STARVE         = 4,
  localparam int unsigned TBL_DW = TBL_NUM_COLS * C_S_AXI_DATA_WIDTH,
  localparam int unsigned TBL_AW = tbl_clog2(TBL_NUM_ROWS)
) (
  input  logic              Bus2IP_Clk,
  input  logic              Bus2IP_Resetn,
  input  logic              tbl_rd_req,
  input  logic [TBL_AW-1:0] tbl_rd_addr,
  output logic              tbl_rd_ack,
  output logic [TBL_DW-1:0] tbl_rd_data,
  input  logic              tbl_wr_req,
  input  logic [TBL_AW-1:0] tbl_wr_addr,
  input  logic [TBL_DW-1:0] tbl_wr_data,
  output logic              tbl_wr_ack,
  input  logic              lu_req,
  input  logic [TBL_AW-1:0] lu_addr,
  output logic              lu_gnt,
  output logic              lu_rd_valid,
  output logic [TBL_DW-1:0] lu_rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [TBL_AW-1:0] mem_addr,
  output logic [TBL_DW-1:0] mem_wdata,
  input  logic [TBL_DW-1:0] mem_rdata,
  output logic [15:0]       stat_host_stall
);

  localparam int unsigned STARVE_W = tbl_clog2(MAX_STARVE + 1);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [15:0]         stall_q, stall_d;
  logic [TBL_DW-1:0]   rd_data_q, rd_data_d;
  logic                lu_vld_q, lu_vld_d;

  logic host_pend, host_win, host_wr_win, host_rd_win, lu_win, starve_full;

  // Arbitration. Combinational outputs are also held inactive while reset
  // is asserted so every output shows its reset value immediately.
  always_comb begin
    starve_full = (starve_q == STARVE_W'(MAX_STARVE));
    host_pend   = Bus2IP_Resetn & (tbl_wr_req | tbl_rd_req) & (state_q == ST_IDLE);
    host_win    = host_pend & (~lu_req | starve_full);
    host_wr_win = host_win & tbl_wr_req;
    host_rd_win = host_win & ~tbl_wr_req;
    lu_win      = Bus2IP_Resetn & lu_req & ~host_win;
  end

  // RAM port driven straight from the winner; one access per cycle.
  always_comb begin
    mem_en    = host_win | lu_win;
    mem_we    = host_wr_win;
    mem_wdata = tbl_wr_data;
    if (host_win) mem_addr = tbl_wr_req ? tbl_wr_addr : tbl_rd_addr;
    else          mem_addr = lu_addr;
  end

  // State register and datapath flops.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      stall_q   <= '0;
      rd_data_q <= '0;
      lu_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      rd_data_q <= rd_data_d;
      lu_vld_q  <= lu_vld_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host_wr_win)      state_d = ST_H_WRACK;
        else if (host_rd_win) state_d = ST_H_RD;
      end
      ST_H_WRACK: state_d = ST_H_GAP;
      ST_H_RD:    state_d = ST_H_RDACK;
      ST_H_RDACK: state_d = ST_H_GAP;
      ST_H_GAP:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Counters, read capture and lookup valid.
  always_comb begin
    // A lookup win while the host waits extends the starvation run;
    // anything else (host win or no host pending) ends it.
    starve_d = '0;
    stall_d  = stall_q;
    if (host_pend & lu_win) begin
      starve_d = starve_full ? starve_q : starve_q + STARVE_W'(1);
      if (stall_q != '1) stall_d = stall_q + 16'd1;
    end
    // mem_rdata in H_RD belongs to the host read issued the cycle before.
    rd_data_d = (state_q == ST_H_RD) ? mem_rdata : rd_data_q;
    lu_vld_d  = lu_win;
  end

  // Output decode.
  always_comb begin
    tbl_wr_ack      = (state_q == ST_H_WRACK);
    tbl_rd_ack      = (state_q == ST_H_RDACK);
    tbl_rd_data     = rd_data_q;
    lu_gnt          = lu_win;
    lu_rd_valid     = lu_vld_q;
    lu_rd_data      = mem_rdata;
    stat_host_stall = stall_q;
  end

endmodule

// File: tb/tb_ipif_tbl_arbiter.sv
module tb_ipif_tbl_arbiter;

  localparam int DW   = 128;
  localparam int AW   = 2;
  localparam int ROWS = 4;
  localparam int MS   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tbl_rd_req, tbl_rd_ack, tbl_wr_req, tbl_wr_ack;
  logic [AW-1:0] tbl_rd_addr, tbl_wr_addr, lu_addr, mem_addr;
  logic [DW-1:0] tbl_rd_data, tbl_wr_data, lu_rd_data, mem_wdata, mem_rdata;
  logic          lu_req, lu_gnt, lu_rd_valid, mem_en, mem_we;
  logic [15:0]   stat_host_stall;

  always #5 clk = ~clk;

  ipif_tbl_arbiter #(
    .C_S_AXI_DATA_WIDTH(32),
    .TBL_NUM_COLS(4),
    .TBL_NUM_ROWS(4),
    .MAX_STARVE(MS)
  ) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n),
    .tbl_rd_req(tbl_rd_req), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_ack(tbl_rd_ack),
    .tbl_rd_data(tbl_rd_data),
    .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .tbl_wr_ack(tbl_wr_ack),
    .lu_req(lu_req), .lu_addr(lu_addr), .lu_gnt(lu_gnt), .lu_rd_valid(lu_rd_valid),
    .lu_rd_data(lu_rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stat_host_stall(stat_host_stall)
  );

  // External single-port RAM, 1-cycle read latency.
  logic [DW-1:0] ram [ROWS];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model: table contents as the host has committed them.
  logic [DW-1:0] ref_mem [ROWS];

  typedef struct { int addr; int due; } lu_t;
  typedef struct { int addr; logic [DW-1:0] data; } wr_t;
  lu_t lu_q[$];
  wr_t wr_q[$];
  int  host_rd_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_le(input string nm, input int act, input int bound);
    checks++;
    if (act < 0 || act > bound) begin
      errors++;
      $display("FAIL %s: got %0d expected <= %0d (cycle %0d)", nm, act, bound, cyc);
    end
  endtask

  // Monitor: lookup results are due exactly one cycle after the grant;
  // host acks consume the oldest outstanding host operation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (lu_q.size() > 0 && lu_q[0].due == cyc) begin
        chk("lu_rd_valid", lu_rd_valid, 1);
        if (lu_rd_valid) chk("lu_rd_data", lu_rd_data, ref_mem[lu_q[0].addr]);
        void'(lu_q.pop_front());
      end else begin
        chk("lu_rd_valid_idle", lu_rd_valid, 0);
      end
      if (tbl_rd_ack) begin
        if (host_rd_q.size() == 0) chk("tbl_rd_ack_unexpected", tbl_rd_ack, 0);
        else begin
          chk("tbl_rd_data", tbl_rd_data, ref_mem[host_rd_q[0]]);
          void'(host_rd_q.pop_front());
        end
      end
      if (tbl_wr_ack) begin
        if (wr_q.size() == 0) chk("tbl_wr_ack_unexpected", tbl_wr_ack, 0);
        else begin
          ref_mem[wr_q[0].addr] = wr_q[0].data;
          void'(wr_q.pop_front());
        end
      end
    end
  end

  task automatic lu_cycle(input bit req, input int a, output bit g);
    @(posedge clk); #1;
    lu_req  = req;
    lu_addr = AW'(a);
    @(negedge clk);
    g = lu_req & lu_gnt;
    if (g) lu_q.push_back('{a, cyc + 1});
  endtask

  // Host operation: level request held until ack and through one extra
  // cycle (a late drop); returns cycles from request to ack.
  task automatic host_op(input bit wr, input int a, input logic [DW-1:0] d, output int lat);
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    if (wr) begin
      wr_q.push_back('{a, d});
      tbl_wr_req = 1'b1; tbl_wr_addr = AW'(a); tbl_wr_data = d;
    end else begin
      host_rd_q.push_back(a);
      tbl_rd_req = 1'b1; tbl_rd_addr = AW'(a);
    end
    lat = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if ((wr ? tbl_wr_ack : tbl_rd_ack) === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) chk_le(wr ? "wr_ack_timeout" : "rd_ack_timeout", lat, 50);
    @(posedge clk); @(posedge clk); #1;
    tbl_wr_req = 1'b0;
    tbl_rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0;
    bit g;
    bit host_done;
    logic [7:0] gnt_bits;
    logic [DW-1:0] a5, d;

    rst_n = 1'b0;
    tbl_rd_req = 0; tbl_wr_req = 0; lu_req = 0;
    tbl_rd_addr = '0; tbl_wr_addr = '0; tbl_wr_data = '0; lu_addr = '0;
    a5 = {16{8'hA5}};

    // Reset values
    #12;
    chk("rst_rd_ack", tbl_rd_ack, 0);
    chk("rst_wr_ack", tbl_wr_ack, 0);
    chk("rst_lu_valid", lu_rd_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rd_data", tbl_rd_data, '0);
    chk("rst_stall", stat_host_stall, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload every row; uncontested write ack one cycle after request
    for (int r = 0; r < ROWS; r++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      host_op(1'b1, r, d, lat);
      chk("preload_wr_latency", lat, 1);
    end

    // Write row 2 then read it back
    @(posedge clk); #1;
    wr_q.push_back('{2, a5});
    tbl_wr_req = 1'b1; tbl_wr_addr = 2'd2; tbl_wr_data = a5;
    @(negedge clk);
    chk("t1_mem_we_at_G", mem_we, 1);
    chk("t1_mem_addr_at_G", mem_addr, 2);
    chk("t1_wr_ack_not_at_G", tbl_wr_ack, 0);
    @(negedge clk);
    chk("t1_wr_ack_at_G1", tbl_wr_ack, 1);
    @(negedge clk);
    chk("t1_wr_ack_single", tbl_wr_ack, 0);
    @(posedge clk); #1 tbl_wr_req = 1'b0;
    host_op(1'b0, 2, '0, lat);
    chk("t1_rd_latency", lat, 2);
    chk("t1_rd_data_a5", tbl_rd_data, a5);

    // Back-to-back lookups
    for (int i = 0; i < 4; i++) begin
      lu_cycle(1'b1, i, g);
      chk("t2_lu_gnt", g, 1);
    end
    @(posedge clk); #1 lu_req = 1'b0;
    @(negedge clk);
    chk("t2_idle_mem_en", mem_en, 0);
    repeat (2) @(posedge clk);

    // Starvation: MAX_STARVE lookup wins, one host win, lookups resume;
    // the lookup right after the host grant reads a different row
    fork
      host_op(1'b0, 1, '0, lat);
      for (int i = 0; i < 8; i++) begin
        lu_cycle(1'b1, (i + 2) % ROWS, g);
        gnt_bits[i] = g;
      end
    join
    lu_req = 1'b0;
    chk("t3_gnt_pattern", gnt_bits, 8'b1110_1111);
    chk("t3_rd_latency", lat, MS + 2);
    chk("t3_stall_count", stat_host_stall, MS);
    repeat (2) @(posedge clk);

    // Simultaneous write and read: write first, read after the gap
    d = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    t0 = cyc;
    wr_q.push_back('{3, d});
    host_rd_q.push_back(3);
    tbl_wr_req = 1'b1; tbl_wr_addr = 2'd3; tbl_wr_data = d;
    tbl_rd_req = 1'b1; tbl_rd_addr = 2'd3;
    @(negedge clk);
    chk("t5_write_first", mem_we, 1);
    @(negedge clk);
    chk("t5_wr_ack", tbl_wr_ack, 1);
    @(posedge clk); @(posedge clk); #1 tbl_wr_req = 1'b0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tbl_rd_ack === 1'b1) begin lat = cyc - t0; break; end
    end
    chk("t5_rd_after_gap", lat, 5);
    @(posedge clk); @(posedge clk); #1 tbl_rd_req = 1'b0;
    repeat (4) @(posedge clk);

    // Reset while in H_RD
    @(posedge clk); #1;
    tbl_rd_req = 1'b1; tbl_rd_addr = 2'd0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rd_ack", tbl_rd_ack, 0);
    chk("t6_rd_data", tbl_rd_data, '0);
    chk("t6_lu_valid", lu_rd_valid, 0);
    chk("t6_mem_en", mem_en, 0);
    chk("t6_mem_we", mem_we, 0);
    chk("t6_stall", stat_host_stall, 0);
    tbl_rd_req = 1'b0;
    lu_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Randomised mix: lookups alongside host reads/writes
    host_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          bit wr;
          int a;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          wr = ($urandom_range(0, 1) == 1);
          a  = $urandom_range(0, ROWS - 1);
          d  = {$urandom, $urandom, $urandom, $urandom};
          host_op(wr, a, d, lat);
          if (wr) chk_le("rand_wr_latency", lat, MS + 1);
          else    chk_le("rand_rd_latency", lat, MS + 2);
        end
        host_done = 1'b1;
      end
      begin
        bit gg;
        while (!host_done) lu_cycle($urandom_range(0, 99) < 75, $urandom_range(0, ROWS - 1), gg);
      end
    join
    @(posedge clk); #1 lu_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_lu_q", lu_q.size(), 0);
    chk("drain_rd_q", host_rd_q.size(), 0);
    chk("drain_wr_q", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
